pc_fetch_ctrl: RTL and testbench

//  Parametrised successor of the pipeline PC register: holds the fetch PC and drives a

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 44 ++++
 rtl/pc_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the IF-stage fetch PC controller
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      PEND  = 2'd2
   } fetch_state_t;

   localparam int          DEF_WIDTH      = 32;
   localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
   localparam int          DEF_INSN_BYTES = 4;

   // Instructions are word aligned: the low two address bits of a target must be zero.
   localparam int          ALIGN_BITS     = 2;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - priority mux exception/redirect/sequential (optional PC_ALIGN_CHECK_EN)
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
   parameter int               INSN_BYTES = DEF_INSN_BYTES
) (
   input  logic             exc_valid,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic [WIDTH-1:0] pc,
   output logic             event_valid,
   output logic [WIDTH-1:0] event_target,
   output logic [WIDTH-1:0] pc_seq
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic             misaligned
`endif
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((1 << ALIGN_BITS) - 1);

   // Exception outranks redirect; the sequential address wraps modulo 2^WIDTH.
   always_comb begin
      event_valid = exc_valid | redirect_valid;
      pc_seq      = pc + WIDTH'(INSN_BYTES);
`ifdef PC_ALIGN_CHECK_EN
      misaligned  = redirect_valid & (|(redirect_target & ALIGN_MASK));
      if (exc_valid || misaligned) begin
         event_target = EXC_VECTOR;
      end else begin
         event_target = redirect_target;
      end
`else
      if (exc_valid) begin
         event_target = EXC_VECTOR;
      end else begin
         event_target = redirect_target & ~ALIGN_MASK;
      end
`endif
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch PC register with stall, redirect deferral and kill (optional PC_ALIGN_CHECK_EN)
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(DEF_RESET_ADDR),
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
   parameter int               INSN_BYTES = DEF_INSN_BYTES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             exc_valid,
   output logic             if_req_valid,
   output logic [WIDTH-1:0] if_req_addr,
   input  logic             if_req_ready,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             kill
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic             misalign
`endif
);

   fetch_state_t     state, state_d;
   logic [WIDTH-1:0] pc_d, pend_addr, pend_d;
   logic             req_hold, kill_d, accept;
   logic             event_valid;
   logic [WIDTH-1:0] event_target;
`ifdef PC_ALIGN_CHECK_EN
   logic             misaligned;
`endif

   pc_next_sel #(
      .WIDTH      (WIDTH),
      .EXC_VECTOR (EXC_VECTOR),
      .INSN_BYTES (INSN_BYTES)
   ) u_next_sel (
      .exc_valid       (exc_valid),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .pc              (pc),
      .event_valid     (event_valid),
      .event_target    (event_target),
      .pc_seq          (pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .misaligned      (misaligned)
`endif
   );

   // Once raised, a request is held by req_hold so stall can never withdraw it.
   assign if_req_valid = (state != BOOT) & (req_hold | ~stall);
   assign accept       = if_req_valid & if_req_ready;
   assign if_req_addr  = pc;

   // Next-state logic: redirects seen while a request is outstanding are parked in pend_addr.
   always_comb begin
      state_d = state;
      pc_d    = pc;
      pend_d  = pend_addr;
      kill_d  = 1'b0;
      case (state)
         BOOT: begin
            // Events during the single boot cycle are ignored; no request is issued.
            state_d = FETCH;
         end
         FETCH: begin
            if (event_valid) begin
               if (accept) begin
                  pc_d   = event_target;
                  kill_d = 1'b1;
               end else if (!if_req_valid) begin
                  pc_d = event_target;
               end else begin
                  pend_d  = event_target;
                  state_d = PEND;
               end
            end else if (accept) begin
               pc_d = pc_plus4;
            end
         end
         PEND: begin
            if (accept) begin
               pc_d    = event_valid ? event_target : pend_addr;
               kill_d  = 1'b1;
               state_d = FETCH;
            end else if (event_valid) begin
               pend_d = event_target;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State and datapath registers; asynchronous reset discards any parked redirect.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= BOOT;
         pc        <= RESET_ADDR;
         pend_addr <= '0;
         req_hold  <= 1'b0;
         kill      <= 1'b0;
      end else begin
         state     <= state_d;
         pc        <= pc_d;
         pend_addr <= pend_d;
         req_hold  <= if_req_valid & ~if_req_ready;
         kill      <= kill_d;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   // One-cycle flag following a misaligned redirect that was turned into an exception.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         misalign <= 1'b0;
      end else begin
         misalign <= (state != BOOT) & misaligned;
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed bench for pc_fetch_ctrl (optional PC_ALIGN_CHECK_EN)
module tb_pc_fetch_ctrl;

   typedef struct packed {
      logic        s;
      logic        r;
      logic        rv;
      logic [31:0] rt;
      logic        ev;
      logic        v;
      logic        k;
      logic [31:0] a;
   } vec_t;

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [31:0] MIS_TGT = 32'h0000_4180;
`else
   localparam logic [31:0] MIS_TGT = 32'h0000_5000;
`endif

   logic        clock, reset, stall, redirect_valid, exc_valid, if_req_ready;
   logic [31:0] redirect_target;
   logic        if_req_valid, kill;
   logic [31:0] if_req_addr, pc, pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
   logic        misalign;
`endif
   int          checks = 0;
   int          errors = 0;

   pc_fetch_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .exc_valid       (exc_valid),
      .if_req_valid    (if_req_valid),
      .if_req_addr     (if_req_addr),
      .if_req_ready    (if_req_ready),
      .pc              (pc),
      .pc_plus4        (pc_plus4),
      .kill            (kill)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .misalign        (misalign)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic drive(input logic s, input logic r, input logic rv, input logic [31:0] rt,
                        input logic ev);
      stall           = s;
      if_req_ready    = r;
      redirect_valid  = rv;
      redirect_target = rt;
      exc_valid       = ev;
      #1;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drive(0, 0, 0, 32'h0, 0);
      #10;
      checks++;
      if ({if_req_valid, kill, pc, pc_plus4} !== {1'b0, 1'b0, 32'h3000, 32'h3004}) begin
         errors++;
         $display("FAIL reset got v=%b k=%b pc=%h p4=%h exp v=0 k=0 pc=3000 p4=3004",
                  if_req_valid, kill, pc, pc_plus4);
      end
      tick();
      reset = 1'b0;
      drive(0, 1, 0, 32'h0, 0);
      checks++;
      if ({if_req_valid, kill, pc} !== {1'b0, 1'b0, 32'h3000}) begin
         errors++;
         $display("FAIL boot got v=%b k=%b pc=%h exp v=0 k=0 pc=3000", if_req_valid, kill, pc);
      end
      tick();
   endtask

   task automatic test_sequential;
      vec_t tv [3];
      tv = '{ '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3000},
              '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3004},
              '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3008} };
      foreach (tv[i]) begin
         drive(tv[i].s, tv[i].r, tv[i].rv, tv[i].rt, tv[i].ev);
         checks++;
         if ({if_req_valid, kill, if_req_addr, pc} !== {tv[i].v, tv[i].k, tv[i].a, tv[i].a}) begin
            errors++;
            $display("FAIL seq[%0d] got v=%b k=%b a=%h pc=%h exp v=%b k=%b a=%h",
                     i, if_req_valid, kill, if_req_addr, pc, tv[i].v, tv[i].k, tv[i].a);
         end
         tick();
      end
   endtask

   task automatic test_ready_hold;
      vec_t tv [4];
      tv = '{ '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3008},
              '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3008},
              '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3008},
              '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3008} };
      foreach (tv[i]) begin
         drive(tv[i].s, tv[i].r, tv[i].rv, tv[i].rt, tv[i].ev);
         checks++;
         if ({if_req_valid, kill, if_req_addr, pc} !== {tv[i].v, tv[i].k, tv[i].a, tv[i].a}) begin
            errors++;
            $display("FAIL hold[%0d] got v=%b k=%b a=%h pc=%h exp v=%b k=%b a=%h",
                     i, if_req_valid, kill, if_req_addr, pc, tv[i].v, tv[i].k, tv[i].a);
         end
         tick();
      end
   endtask

   task automatic test_pend_redirect;
      vec_t tv [5];
      tv = '{ '{1'b0, 1'b0, 1'b1, 32'h3100, 1'b0, 1'b1, 1'b0, 32'h300C},
              '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h300C},
              '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h3100},
              '{1'b0, 1'b1, 1'b1, 32'h3200, 1'b1, 1'b1, 1'b0, 32'h3104},
              '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h4180} };
      foreach (tv[i]) begin
         drive(tv[i].s, tv[i].r, tv[i].rv, tv[i].rt, tv[i].ev);
         checks++;
         if ({if_req_valid, kill, if_req_addr, pc} !== {tv[i].v, tv[i].k, tv[i].a, tv[i].a}) begin
            errors++;
            $display("FAIL pend[%0d] got v=%b k=%b a=%h pc=%h exp v=%b k=%b a=%h",
                     i, if_req_valid, kill, if_req_addr, pc, tv[i].v, tv[i].k, tv[i].a);
         end
         tick();
      end
   endtask

   task automatic test_pend_overwrite;
      vec_t tv [6];
      tv = '{ '{1'b0, 1'b0, 1'b1, 32'h5000, 1'b0, 1'b1, 1'b0, 32'h4184},
              '{1'b0, 1'b0, 1'b1, 32'h6000, 1'b1, 1'b1, 1'b0, 32'h4184},
              '{1'b1, 1'b0, 1'b1, 32'h7000, 1'b0, 1'b1, 1'b0, 32'h4184},
              '{1'b1, 1'b1, 1'b1, 32'h8000, 1'b1, 1'b1, 1'b0, 32'h4184},
              '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h4180},
              '{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h4180} };
      foreach (tv[i]) begin
         drive(tv[i].s, tv[i].r, tv[i].rv, tv[i].rt, tv[i].ev);
         checks++;
         if ({if_req_valid, kill, if_req_addr, pc} !== {tv[i].v, tv[i].k, tv[i].a, tv[i].a}) begin
            errors++;
            $display("FAIL ovr[%0d] got v=%b k=%b a=%h pc=%h exp v=%b k=%b a=%h",
                     i, if_req_valid, kill, if_req_addr, pc, tv[i].v, tv[i].k, tv[i].a);
         end
         tick();
      end
   endtask

   task automatic test_stall_event;
      drive(1, 1, 0, 32'h0, 0);
      checks++;
      if ({if_req_valid, kill, pc} !== {1'b0, 1'b0, 32'h4184}) begin
         errors++;
         $display("FAIL stall_idle got v=%b k=%b pc=%h exp v=0 k=0 pc=4184", if_req_valid, kill, pc);
      end
      tick();
      drive(1, 1, 1, 32'h5002, 0);
      checks++;
      if ({if_req_valid, pc} !== {1'b0, 32'h4184}) begin
         errors++;
         $display("FAIL stall_evt got v=%b pc=%h exp v=0 pc=4184", if_req_valid, pc);
      end
      tick();
      drive(1, 1, 0, 32'h0, 0);
      checks++;
      if ({if_req_valid, kill, pc} !== {1'b0, 1'b0, MIS_TGT}) begin
         errors++;
         $display("FAIL stall_tgt got v=%b k=%b pc=%h exp v=0 k=0 pc=%h",
                  if_req_valid, kill, pc, MIS_TGT);
      end
`ifdef PC_ALIGN_CHECK_EN
      checks++;
      if (misalign !== 1'b1) begin
         errors++;
         $display("FAIL misalign got %b exp 1", misalign);
      end
`endif
      tick();
   endtask

   task automatic test_wrap;
      drive(0, 1, 1, 32'hFFFF_FFFC, 0);
      checks++;
      if ({if_req_valid, kill, if_req_addr} !== {1'b1, 1'b0, MIS_TGT}) begin
         errors++;
         $display("FAIL wrap_pre got v=%b k=%b a=%h exp v=1 k=0 a=%h",
                  if_req_valid, kill, if_req_addr, MIS_TGT);
      end
      tick();
      drive(0, 1, 0, 32'h0, 0);
      checks++;
      if ({if_req_valid, kill, if_req_addr, pc_plus4} !== {1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0}) begin
         errors++;
         $display("FAIL wrap_top got v=%b k=%b a=%h p4=%h exp v=1 k=1 a=fffffffc p4=0",
                  if_req_valid, kill, if_req_addr, pc_plus4);
      end
      tick();
      drive(0, 0, 0, 32'h0, 0);
      checks++;
      if ({if_req_valid, kill, if_req_addr, pc_plus4} !== {1'b1, 1'b0, 32'h0, 32'h4}) begin
         errors++;
         $display("FAIL wrap_zero got v=%b k=%b a=%h p4=%h exp v=1 k=0 a=0 p4=4",
                  if_req_valid, kill, if_req_addr, pc_plus4);
      end
      tick();
   endtask

   task automatic test_reset_mid_pend;
      drive(0, 0, 1, 32'h3100, 0);
      tick();
      drive(0, 0, 0, 32'h0, 0);
      checks++;
      if ({if_req_valid, pc} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL rst_pend got v=%b pc=%h exp v=1 pc=0", if_req_valid, pc);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({if_req_valid, kill, pc} !== {1'b0, 1'b0, 32'h3000}) begin
         errors++;
         $display("FAIL rst_async got v=%b k=%b pc=%h exp v=0 k=0 pc=3000", if_req_valid, kill, pc);
      end
      tick();
      reset = 1'b0;
      drive(0, 1, 0, 32'h0, 0);
      checks++;
      if ({if_req_valid, kill} !== {1'b0, 1'b0}) begin
         errors++;
         $display("FAIL rst_boot got v=%b k=%b exp v=0 k=0", if_req_valid, kill);
      end
      tick();
      drive(0, 1, 0, 32'h0, 0);
      checks++;
      if ({if_req_valid, kill, if_req_addr} !== {1'b1, 1'b0, 32'h3000}) begin
         errors++;
         $display("FAIL rst_first got v=%b k=%b a=%h exp v=1 k=0 a=3000", if_req_valid, kill, if_req_addr);
      end
      tick();
      drive(0, 1, 0, 32'h0, 0);
      checks++;
      if ({if_req_valid, kill, if_req_addr} !== {1'b1, 1'b0, 32'h3004}) begin
         errors++;
         $display("FAIL rst_next got v=%b k=%b a=%h exp v=1 k=0 a=3004", if_req_valid, kill, if_req_addr);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_ready_hold();
      test_pend_redirect();
      test_pend_overwrite();
      test_stall_event();
      test_wrap();
      test_reset_mid_pend();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
